log_event_serializer: RTL and testbench
=======================================

Name: log_event_serializer

Overview:
- Upstream feeder for the BRAM logger.
- Collects single-cycle event pulses from NUM_SRC independent sources, tags each with its source ID, and buffers them in a FIFO.
- Emits at most one event per cycle on the logger's LogData/LogTrigger inputs, and only while the logger reports Ready.
- Events that cannot be buffered are dropped and counted, so software can judge log completeness.

Parameters:
- NUM_SRC, 4: number of event sources; must be >= 2.
- SRC_DATA_BITW, 24: per-source metadata width.
- LOG_DATA_BITW, 32: output payload width; must be >= SRC_DATA_BITW + SRC_ID_BITW and a multiple of 32.
- FIFO_DEPTH, 16: buffer entries; must be a power of 2 and >= 2.

Ports:
- Clk_CI  in  1  sole clock.
- Rst_RI  in  1  synchronous, active-high reset.
- EvtValid_SI  in  NUM_SRC  per-source event strobe; one event per asserted bit per cycle.
- EvtData_DI  in  NUM_SRC*SRC_DATA_BITW  per-source metadata; source i occupies bits [i*SRC_DATA_BITW +: SRC_DATA_BITW].
- LogEn_SI  in  1  global enable; shared with the logger's LogEn.
- LoggerReady_SI  in  1  the logger's Ready_SO.
- LogData_DO  out  LOG_DATA_BITW  to the logger's LogData_DI.
- LogTrigger_SO  out  1  to the logger's LogTrigger_SI.
- DropCnt_DO  out  32  saturating count of dropped events.
- DropClr_SI  in  1  clears DropCnt_DO and DropSrc_SO.
- DropSrc_SO  out  NUM_SRC  sticky per-source drop flags.
- FifoLevel_DO  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset:
  - Clears all pending registers, FIFO pointers and level, DropCnt_DO, DropSrc_SO.
  - Sets the RR pointer to NUM_SRC-1, so source 0 wins first.
  - LogTrigger_SO=0, LogData_DO=0, FifoLevel_DO=0.
  - A mid-operation reset discards all buffered events without counting them as drops.
- Stage 1, per-source pending register (valid + data):
  - Loads when EvtValid_SI[i] & LogEn_SI, and the register is either empty or being granted this cycle.
  - If EvtValid_SI[i] & LogEn_SI while the register is occupied and not granted, the event is dropped.
  - LogEn_SI=0: inputs are ignored; they are neither captured nor counted.
- Stage 2, round-robin arbiter:
  - Grants the first pending source at an index above the last grant, modulo NUM_SRC.
  - At most one grant per cycle, and only if the FIFO can push (level < FIFO_DEPTH, or a pop occurs this cycle).
  - The RR pointer updates only on a grant.
  - The granted entry is pushed as {zeros, src_id[SRC_ID_BITW-1:0], data[SRC_DATA_BITW-1:0]}; data sits at the LSBs and the ID immediately above it.
- Stage 3, output:
  - LogTrigger_SO = ~empty & LoggerReady_SI & LogEn_SI.
  - LogData_DO = FIFO head; driven as 0 when the FIFO is empty.
  - A pop occurs exactly when LogTrigger_SO=1; no handshake beyond Ready.
- Latency: an event at cycle t on an idle block appears on LogTrigger_SO in cycle t+2.
  - Throughput: 1 event/cycle sustained.
  - Push and pop in the same cycle: level unchanged. This is legal at full and at level 1.
- Logger clearing or full (LoggerReady_SI=0): the FIFO holds, then pending registers fill, then drops start. No event is lost while buffer space remains.
- Drop accounting:
  - DropCnt_DO increments by popcount(drops this cycle) and saturates at 0xFFFFFFFF.
  - DropSrc_SO[i] sets on a drop from source i.
  - DropClr_SI takes effect first: on simultaneous clear and drop, the result equals the drops of that cycle only.
- FIFO pointers wrap modulo FIFO_DEPTH. The level counter is separate, so full and empty are unambiguous.

Decomposition:
- Package log_event_pkg holds:
  - SRC_ID_BITW = log2(NUM_SRC), using the shared CfMath log2.
  - A packed entry typedef {src_id, data}.
  - A function that formats an entry into LOG_DATA_BITW.
- One sub-module, log_event_fifo: single-clock FIFO, one push and one pop per cycle, registered storage with a combinational head, level output.
- Arbiter and pending registers stay in the top module.

Test Plan:
1. Single event: src 2 pulses data 0xABCDEF at cycle 0 with LoggerReady=1 → cycle 2: LogTrigger_SO=1 and LogData_DO=0x02ABCDEF; DropCnt stays 0.
2. Simultaneous burst: all 4 sources pulse in one cycle → 4 triggers on cycles 2..5, in source order 0,1,2,3; no drops.
3. Round-robin fairness: sources 0 and 3 pulse every cycle with LoggerReady=1 → output alternates 0,3,0,3.
   - Drops accrue because each source produces 1 event/cycle against a 1/2 service rate.
   - DropCnt tracks the count exactly.
4. Backpressure: LoggerReady=0 while src 0 pulses 20 times, FIFO_DEPTH=16 → 16 entries held, 1 pending, 3 dropped.
   - DropCnt=3 and DropSrc=0b0001.
   - After LoggerReady rises: 17 triggers in order, then FifoLevel=0.
5. Counter clear and saturation: force DropCnt to 0xFFFFFFFF then drop again → stays 0xFFFFFFFF. DropClr in the same cycle as 2 drops → DropCnt=2.
6. Reset mid-operation: FIFO at level 10, assert Rst_RI for 1 cycle → next cycle LogTrigger_SO=0, FifoLevel=0, DropCnt=0; the next event is again granted to source 0 first.

Source files
------------

// File: rtl/log_event_pkg.sv
// Shared configuration, entry layout and formatting for the log event serializer.
package log_event_pkg;

  localparam int unsigned CFG_NUM_SRC       = 4;
  localparam int unsigned CFG_SRC_DATA_BITW = 24;
  localparam int unsigned CFG_LOG_DATA_BITW = 32;
  localparam int unsigned CFG_FIFO_DEPTH    = 16;

  localparam int unsigned SRC_ID_BITW = $clog2(CFG_NUM_SRC);

  typedef struct packed {
    logic [SRC_ID_BITW-1:0]       src_id;
    logic [CFG_SRC_DATA_BITW-1:0] data;
  } log_entry_t;

  localparam int unsigned ENTRY_BITW = $bits(log_entry_t);

  // Zero-extend an entry so data lands at the LSBs with the source ID right above it.
  function automatic logic [CFG_LOG_DATA_BITW-1:0] format_entry(input log_entry_t entry);
    return {{(CFG_LOG_DATA_BITW - ENTRY_BITW){1'b0}}, entry};
  endfunction

endpackage

// File: rtl/log_event_fifo.sv
// Single-clock FIFO of log entries: one push and one pop per cycle,
// registered storage, combinational head, separate level counter.
module log_event_fifo
  import log_event_pkg::*;
#(
  parameter int unsigned DEPTH = CFG_FIFO_DEPTH
) (
  input  logic                   Clk_CI,
  input  logic                   Rst_RI,
  input  logic                   Push_SI,
  input  log_entry_t             PushData_DI,
  input  logic                   Pop_SI,
  output log_entry_t             Head_DO_c,
  output logic                   Empty_SO_c,
  output logic                   Full_SO_c,
  output logic [$clog2(DEPTH):0] Level_DO
);

  localparam int unsigned PTR_BITW = $clog2(DEPTH);
  localparam int unsigned LVL_BITW = PTR_BITW + 1;

  log_entry_t            mem_q [DEPTH];
  logic [PTR_BITW-1:0]   wr_ptr_q;
  logic [PTR_BITW-1:0]   rd_ptr_q;
  logic [LVL_BITW-1:0]   level_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (Push_SI) wr_ptr_q <= wr_ptr_q + PTR_BITW'(1);
      if (Pop_SI)  rd_ptr_q <= rd_ptr_q + PTR_BITW'(1);
      case ({Push_SI, Pop_SI})
        2'b10:   level_q <= level_q + LVL_BITW'(1);
        2'b01:   level_q <= level_q - LVL_BITW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (Push_SI) mem_q[wr_ptr_q] <= PushData_DI;
  end

  assign Empty_SO_c = (level_q == '0);
  assign Full_SO_c  = (level_q == LVL_BITW'(DEPTH));
  assign Head_DO_c  = Empty_SO_c ? '0 : mem_q[rd_ptr_q];
  assign Level_DO   = level_q;

endmodule

// File: rtl/log_event_serializer.sv
// Collects per-source event pulses, round-robin arbitrates them into a FIFO
// and feeds the BRAM logger one entry per cycle while it is ready.
module log_event_serializer
  import log_event_pkg::*;
#(
  parameter int unsigned NUM_SRC       = CFG_NUM_SRC,
  parameter int unsigned SRC_DATA_BITW = CFG_SRC_DATA_BITW,
  parameter int unsigned LOG_DATA_BITW = CFG_LOG_DATA_BITW,
  parameter int unsigned FIFO_DEPTH    = CFG_FIFO_DEPTH
) (
  input  logic                               Clk_CI,
  input  logic                               Rst_RI,
  input  logic [NUM_SRC-1:0]                 EvtValid_SI,
  input  logic [NUM_SRC*SRC_DATA_BITW-1:0]   EvtData_DI,
  input  logic                               LogEn_SI,
  input  logic                               LoggerReady_SI,
  output logic [LOG_DATA_BITW-1:0]           LogData_DO,
  output logic                               LogTrigger_SO,
  output logic [31:0]                        DropCnt_DO,
  input  logic                               DropClr_SI,
  output logic [NUM_SRC-1:0]                 DropSrc_SO,
  output logic [$clog2(FIFO_DEPTH):0]        FifoLevel_DO
);

  logic [NUM_SRC-1:0]       pend_vld_q;
  logic [SRC_DATA_BITW-1:0] pend_data_q [NUM_SRC];
  logic [SRC_ID_BITW-1:0]   rr_ptr_q;

  logic [NUM_SRC-1:0]       evt_en;
  logic [NUM_SRC-1:0]       load;
  logic [NUM_SRC-1:0]       drop;
  logic [NUM_SRC-1:0]       grant_oh;
  logic [SRC_ID_BITW-1:0]   grant_idx;
  logic [SRC_ID_BITW-1:0]   cand_idx;
  logic                     grant_any;
  logic                     grant;
  logic                     pop;
  logic                     fifo_empty;
  logic                     fifo_full;
  log_entry_t               push_entry;
  log_entry_t               head_entry;

  logic [31:0]              drop_cnt_q;
  logic [31:0]              drop_cnt_d;
  logic [31:0]              drop_pop;
  logic [32:0]              drop_sum;
  logic [NUM_SRC-1:0]       drop_src_q;

  assign pop = ~fifo_empty & LoggerReady_SI & LogEn_SI;

  // Round-robin search starting just above the last granted source.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = rr_ptr_q;
    cand_idx  = '0;
    for (int unsigned off = 1; off <= NUM_SRC; off++) begin
      cand_idx = SRC_ID_BITW'((32'(rr_ptr_q) + off) % NUM_SRC);
      if (!grant_any && pend_vld_q[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  // A push is allowed into a full FIFO only when the head leaves in the same cycle.
  assign grant    = grant_any & (~fifo_full | pop);
  assign grant_oh = grant ? (NUM_SRC'(1) << grant_idx) : '0;

  assign evt_en = EvtValid_SI & {NUM_SRC{LogEn_SI}};
  assign load   = evt_en & (~pend_vld_q | grant_oh);
  assign drop   = evt_en & pend_vld_q & ~grant_oh;

  assign push_entry.src_id = grant_idx;
  assign push_entry.data   = pend_data_q[grant_idx];

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      pend_vld_q <= '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) pend_data_q[i] <= '0;
      rr_ptr_q   <= SRC_ID_BITW'(NUM_SRC - 1);
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (load[i]) begin
          pend_vld_q[i]  <= 1'b1;
          pend_data_q[i] <= EvtData_DI[i*SRC_DATA_BITW +: SRC_DATA_BITW];
        end else if (grant_oh[i]) begin
          pend_vld_q[i]  <= 1'b0;
        end
      end
      if (grant) rr_ptr_q <= grant_idx;
    end
  end

  // Clear applies before this cycle's drops are added; the sum saturates.
  always_comb begin
    drop_pop = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) drop_pop = drop_pop + 32'(drop[i]);
    drop_sum   = 33'(DropClr_SI ? 32'd0 : drop_cnt_q) + 33'(drop_pop);
    drop_cnt_d = drop_sum[32] ? '1 : drop_sum[31:0];
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      drop_cnt_q <= '0;
      drop_src_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      drop_src_q <= (DropClr_SI ? '0 : drop_src_q) | drop;
    end
  end

  log_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) i_fifo (
    .Clk_CI      (Clk_CI),
    .Rst_RI      (Rst_RI),
    .Push_SI     (grant),
    .PushData_DI (push_entry),
    .Pop_SI      (pop),
    .Head_DO_c   (head_entry),
    .Empty_SO_c  (fifo_empty),
    .Full_SO_c   (fifo_full),
    .Level_DO    (FifoLevel_DO)
  );

  assign LogTrigger_SO = pop;
  assign LogData_DO    = format_entry(head_entry);
  assign DropCnt_DO    = drop_cnt_q;
  assign DropSrc_SO    = drop_src_q;

endmodule

// File: tb/tb_log_event_serializer.sv
// Scoreboard bench for log_event_serializer: expected log words are queued
// at stimulus time and popped whenever the DUT fires LogTrigger_SO.
module tb_log_event_serializer;
  import log_event_pkg::*;

  localparam int unsigned NS  = CFG_NUM_SRC;
  localparam int unsigned DW  = CFG_SRC_DATA_BITW;
  localparam int unsigned LW  = CFG_LOG_DATA_BITW;
  localparam int unsigned FD  = CFG_FIFO_DEPTH;
  localparam int unsigned LVW = $clog2(FD) + 1;

  logic              Clk_CI = 1'b0;
  logic              Rst_RI = 1'b1;
  logic [NS-1:0]     EvtValid_SI = '0;
  logic [NS*DW-1:0]  EvtData_DI = '0;
  logic              LogEn_SI = 1'b1;
  logic              LoggerReady_SI = 1'b0;
  logic [LW-1:0]     LogData_DO;
  logic              LogTrigger_SO;
  logic [31:0]       DropCnt_DO;
  logic              DropClr_SI = 1'b0;
  logic [NS-1:0]     DropSrc_SO;
  logic [LVW-1:0]    FifoLevel_DO;

  int unsigned   n_checks = 0;
  int unsigned   n_errors = 0;
  logic [LW-1:0] exp_q [$];

  always #5 Clk_CI = ~Clk_CI;

  log_event_serializer dut (
    .Clk_CI         (Clk_CI),
    .Rst_RI         (Rst_RI),
    .EvtValid_SI    (EvtValid_SI),
    .EvtData_DI     (EvtData_DI),
    .LogEn_SI       (LogEn_SI),
    .LoggerReady_SI (LoggerReady_SI),
    .LogData_DO     (LogData_DO),
    .LogTrigger_SO  (LogTrigger_SO),
    .DropCnt_DO     (DropCnt_DO),
    .DropClr_SI     (DropClr_SI),
    .DropSrc_SO     (DropSrc_SO),
    .FifoLevel_DO   (FifoLevel_DO)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [LW-1:0] exp_word(input int unsigned src, input logic [DW-1:0] d);
    return (LW'(src) << DW) | LW'(d);
  endfunction

  // Output monitor: every trigger must match the oldest outstanding expectation.
  always @(negedge Clk_CI) begin
    if (LogTrigger_SO === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_trigger", 64'(LogData_DO), 64'hDEAD);
      else check("log_data", 64'(LogData_DO), 64'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge Clk_CI);
    #1;
  endtask

  task automatic set_evt(input int unsigned src, input logic [DW-1:0] d);
    EvtValid_SI[src]           = 1'b1;
    EvtData_DI[src*DW +: DW]   = d;
  endtask

  task automatic clear_evt();
    EvtValid_SI = '0;
  endtask

  task automatic do_reset();
    Rst_RI = 1'b1;
    clear_evt();
    DropClr_SI = 1'b0;
    tick();
    Rst_RI = 1'b0;
  endtask

  // Events were set in cycle 0; clear them in cycle 1 and check trigger per cycle.
  task automatic watch(input int unsigned n, input int unsigned first, input int unsigned last);
    for (int unsigned c = 0; c <= n; c++) begin
      if (c > 0) begin
        tick();
        if (c == 1) clear_evt();
      end
      @(negedge Clk_CI);
      check($sformatf("trig_cycle%0d", c), 64'(LogTrigger_SO), 64'(c >= first && c <= last));
    end
  endtask

  task automatic wait_drain(input int unsigned max_cyc);
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge Clk_CI);
      n++;
    end
    check("drain_outstanding", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    tick();
    @(negedge Clk_CI);
    check("drain_level", 64'(FifoLevel_DO), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    @(negedge Clk_CI);
    check("rst_trigger", 64'(LogTrigger_SO), 64'd0);
    check("rst_data",    64'(LogData_DO),    64'd0);
    check("rst_level",   64'(FifoLevel_DO),  64'd0);
    check("rst_dropcnt", 64'(DropCnt_DO),    64'd0);
    check("rst_dropsrc", 64'(DropSrc_SO),    64'd0);

    // Single event: two-cycle latency, ID above data.
    LoggerReady_SI = 1'b1;
    tick();
    set_evt(2, 24'hABCDEF);
    exp_q.push_back(32'h02AB_CDEF);
    watch(4, 2, 2);
    check("single_dropcnt", 64'(DropCnt_DO), 64'd0);

    // Disabled logging: events ignored, not counted.
    tick();
    LogEn_SI = 1'b0;
    set_evt(1, 24'h111111);
    watch(4, 1, 0);
    check("logen_dropcnt", 64'(DropCnt_DO), 64'd0);
    check("logen_level", 64'(FifoLevel_DO), 64'd0);
    LogEn_SI = 1'b1;

    // Simultaneous burst from all sources after reset: order 0..3 on cycles 2..5.
    do_reset();
    for (int unsigned i = 0; i < NS; i++) begin
      set_evt(i, 24'h5A0000 | 24'(i));
      exp_q.push_back(exp_word(i, 24'h5A0000 | 24'(i)));
    end
    watch(7, 2, 5);
    check("burst_dropcnt", 64'(DropCnt_DO), 64'd0);

    // Fairness: sources 0 and 3 every cycle for 8 cycles, one drop per cycle after the first.
    do_reset();
    exp_q.push_back(exp_word(0, 24'd0));
    for (int unsigned k = 1; k <= 8; k++) begin
      if (k % 2 == 0) exp_q.push_back(exp_word(0, 24'(k - 1)));
      else            exp_q.push_back(exp_word(3, 24'h300000 | 24'(k - 1)));
    end
    for (int unsigned c = 0; c < 8; c++) begin
      tick();
      set_evt(0, 24'(c));
      set_evt(3, 24'h300000 | 24'(c));
      @(negedge Clk_CI);
      check($sformatf("rr_dropcnt_c%0d", c), 64'(DropCnt_DO), 64'((c == 0) ? 0 : c - 1));
    end
    tick();
    clear_evt();
    wait_drain(40);
    check("rr_dropcnt_final", 64'(DropCnt_DO), 64'd7);
    check("rr_dropsrc", 64'(DropSrc_SO), 64'b1001);

    // Backpressure: 20 pulses into a stalled logger.
    do_reset();
    LoggerReady_SI = 1'b0;
    for (int unsigned i = 0; i < 20; i++) begin
      tick();
      set_evt(0, 24'h400000 | 24'(i));
      if (i < FD) exp_q.push_back(exp_word(0, 24'h400000 | 24'(i)));
    end
    tick();
    clear_evt();
    tick();
    @(negedge Clk_CI);
    check("bp_level",   64'(FifoLevel_DO), 64'(FD));
    check("bp_dropcnt", 64'(DropCnt_DO),   64'd3);
    check("bp_dropsrc", 64'(DropSrc_SO),   64'b0001);
    check("bp_no_trig", 64'(LogTrigger_SO), 64'd0);

    // Park a second pending event on source 1.
    tick();
    set_evt(1, 24'h410000);
    tick();
    clear_evt();
    @(negedge Clk_CI);
    check("bp_src1_nodrop", 64'(DropCnt_DO), 64'd3);

    // Saturation: preset the counter, then drop once more.
    force dut.drop_cnt_q = 32'hFFFF_FFFF;
    @(negedge Clk_CI);
    release dut.drop_cnt_q;
    tick();
    set_evt(0, 24'h4000FF);
    tick();
    clear_evt();
    @(negedge Clk_CI);
    check("sat_dropcnt", 64'(DropCnt_DO), 64'hFFFF_FFFF);

    // Clear together with two drops leaves only this cycle's drops.
    tick();
    set_evt(0, 24'h4000EE);
    set_evt(1, 24'h4100EE);
    DropClr_SI = 1'b1;
    tick();
    clear_evt();
    DropClr_SI = 1'b0;
    @(negedge Clk_CI);
    check("clr_dropcnt", 64'(DropCnt_DO), 64'd2);
    check("clr_dropsrc", 64'(DropSrc_SO), 64'b0011);

    exp_q.push_back(exp_word(1, 24'h410000));
    exp_q.push_back(exp_word(0, 24'h400000 | 24'(FD)));
    tick();
    LoggerReady_SI = 1'b1;
    wait_drain(60);
    check("bp_dropcnt_after", 64'(DropCnt_DO), 64'd2);

    // Mid-operation reset with 10 buffered entries.
    LoggerReady_SI = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      tick();
      set_evt(1, 24'h600000 | 24'(i));
    end
    tick();
    clear_evt();
    repeat (3) tick();
    @(negedge Clk_CI);
    check("pre_rst_level", 64'(FifoLevel_DO), 64'd10);
    tick();
    Rst_RI = 1'b1;
    tick();
    Rst_RI = 1'b0;
    LoggerReady_SI = 1'b1;
    @(negedge Clk_CI);
    check("mid_rst_trigger", 64'(LogTrigger_SO), 64'd0);
    check("mid_rst_level",   64'(FifoLevel_DO),  64'd0);
    check("mid_rst_dropcnt", 64'(DropCnt_DO),    64'd0);
    check("mid_rst_dropsrc", 64'(DropSrc_SO),    64'd0);

    tick();
    set_evt(3, 24'h7000C3);
    set_evt(0, 24'h7000C0);
    exp_q.push_back(exp_word(0, 24'h7000C0));
    exp_q.push_back(exp_word(3, 24'h7000C3));
    watch(5, 2, 3);
    wait_drain(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
